// File: rtl/mem_access_stage.sv
// Memory-access stage: runs one load/store per instruction over a req/ack memory port and
// presents a registered writeback result (lb sign extension, sb lane enables, word access).
// Latency: out_valid at T+1 for faults/pass-through, T+2 minimum for memory accesses
// (ack at T+1). Backpressure: single entry; in_ready is high only in IDLE; the result holds
// while out_ready=0.
// Ports: clk/rst; upstream in_valid/in_ready with the decoder controls (memread, memwrite,
// regwrite, is_lb, is_sb) and addr/wdata/rd_in; memory mem_req/mem_we/mem_addr/mem_be/
// mem_wdata/mem_ack/mem_rdata; writeback out_valid/out_ready/wb_en/wb_rd/wb_data/err.
module mem_access_stage #(
  parameter int XLEN        = 32,
  parameter int ACK_TIMEOUT = 255,
  parameter int CNT_W       = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            memread,
  input  logic            memwrite,
  input  logic            regwrite,
  input  logic            is_lb,
  input  logic            is_sb,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  input  logic [4:0]      rd_in,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [3:0]      mem_be,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            wb_en,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            err
);

  typedef enum logic [1:0] {IDLE, MEM, DONE} state_t;

  // The watchdog times out on the cycle it has already counted ACK_TIMEOUT-1 misses,
  // so mem_req stays high for exactly ACK_TIMEOUT cycles.
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(ACK_TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wdog;
  logic             is_load_q, is_lb_q, regwrite_q;
  logic [1:0]       off_q;

  logic       illegal, misaligned, passthru, wd_hit;
  logic [7:0] rd_byte;

  assign illegal    = memread & memwrite;
  assign misaligned = ((memread & ~is_lb) | (memwrite & ~is_sb)) & (addr[1:0] != 2'b00);
  assign passthru   = ~memread & ~memwrite;
  assign wd_hit     = (wdog == WD_LAST);
  assign rd_byte    = mem_rdata[{off_q, 3'b000} +: 8];
  assign in_ready   = (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = (illegal | misaligned | passthru) ? DONE : MEM;
      MEM:  if (mem_ack | wd_hit) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= 4'h0;
      mem_wdata  <= '0;
      out_valid  <= 1'b0;
      wb_en      <= 1'b0;
      wb_rd      <= 5'd0;
      wb_data    <= '0;
      err        <= 1'b0;
      wdog       <= '0;
      is_load_q  <= 1'b0;
      is_lb_q    <= 1'b0;
      regwrite_q <= 1'b0;
      off_q      <= 2'b00;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          wb_rd      <= rd_in;
          is_load_q  <= memread;
          is_lb_q    <= is_lb;
          regwrite_q <= regwrite;
          off_q      <= addr[1:0];
          wdog       <= '0;
          if (illegal | misaligned) begin
            out_valid <= 1'b1;
            err       <= 1'b1;
            wb_en     <= 1'b0;
            wb_data   <= '0;
          end else if (passthru) begin
            out_valid <= 1'b1;
            err       <= 1'b0;
            wb_en     <= regwrite;
            wb_data   <= addr;
          end else begin
            mem_req  <= 1'b1;
            mem_we   <= memwrite;
            mem_addr <= {addr[XLEN-1:2], 2'b00};
            if (memwrite & is_sb) begin
              mem_be    <= 4'b0001 << addr[1:0];
              mem_wdata <= {(XLEN/8){wdata[7:0]}};
            end else begin
              mem_be    <= 4'hF;
              mem_wdata <= wdata;
            end
          end
        end
        MEM: begin
          if (mem_ack) begin
            mem_req   <= 1'b0;
            out_valid <= 1'b1;
            err       <= 1'b0;
            if (is_load_q) begin
              wb_en   <= regwrite_q;
              wb_data <= is_lb_q ? {{(XLEN-8){rd_byte[7]}}, rd_byte} : mem_rdata;
            end else begin
              wb_en   <= 1'b0;
              wb_data <= '0;
            end
          end else if (wd_hit) begin
            mem_req   <= 1'b0;
            out_valid <= 1'b1;
            err       <= 1'b1;
            wb_en     <= 1'b0;
            wb_data   <= '0;
          end else begin
            wdog <= wdog + CNT_W'(1);
          end
        end
        DONE: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed vector table, reset-abort sequence, then randomized
// transactions checked against a behavioural model of the access rules.
module tb_mem_access_stage;

  localparam int ACK_TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, memread, memwrite, regwrite, is_lb, is_sb;
  logic [31:0] addr, wdata, mem_addr, mem_wdata, mem_rdata, wb_data;
  logic [4:0]  rd_in, wb_rd;
  logic        mem_req, mem_we, mem_ack, out_valid, out_ready, wb_en, err;
  logic [3:0]  mem_be;

  int n_cmp = 0;
  int n_err = 0;

  mem_access_stage #(.XLEN(32), .ACK_TIMEOUT(ACK_TO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .memread(memread), .memwrite(memwrite), .regwrite(regwrite), .is_lb(is_lb), .is_sb(is_sb),
    .addr(addr), .wdata(wdata), .rd_in(rd_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .wb_en(wb_en), .wb_rd(wb_rd),
    .wb_data(wb_data), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic mr, mw, rw, lb, sb;
    logic [31:0] addr, wdata;
    logic [4:0] rd;
    int ack_dly;            // ack in the (ack_dly+1)-th cycle of mem_req
    logic [31:0] rdata;
    int hold;               // cycles out_ready is held low once out_valid rises
    int e_reqcyc;
    logic e_we;
    logic [3:0] e_be;
    logic [31:0] e_maddr, e_mwdata;
    int e_lat;
    logic e_wben;
    logic [31:0] e_wbdata;
    logic e_err;
  } vec_t;

  typedef struct {
    int reqcyc, lat;
    logic we;
    logic [3:0] be;
    logic [31:0] maddr, mwdata, wbdata;
    logic wben, errv, req_at_done, rdy_at_done;
    logic [4:0] wbrd;
    bit stable, hold_stable, rel_ok;
  } obs_t;

  vec_t vecs[10];

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic vec_t vin(logic mr, logic mw, logic rw, logic lb, logic sb,
                               logic [31:0] a, logic [31:0] wd, logic [4:0] rd,
                               int ackd, logic [31:0] rdat, int hold);
    vec_t v;
    v = '{default: 0};
    v.mr = mr; v.mw = mw; v.rw = rw; v.lb = lb; v.sb = sb;
    v.addr = a; v.wdata = wd; v.rd = rd; v.ack_dly = ackd; v.rdata = rdat; v.hold = hold;
    return v;
  endfunction

  function automatic vec_t vexp(vec_t v, int reqcyc, logic we, logic [3:0] be,
                                logic [31:0] maddr, logic [31:0] mwd, int lat,
                                logic wben, logic [31:0] wbd, logic e);
    vec_t r;
    r = v;
    r.e_reqcyc = reqcyc; r.e_we = we; r.e_be = be; r.e_maddr = maddr; r.e_mwdata = mwd;
    r.e_lat = lat; r.e_wben = wben; r.e_wbdata = wbd; r.e_err = e;
    return r;
  endfunction

  // Behavioural reference: derives expectations from the access rules directly.
  function automatic vec_t model(vec_t v);
    vec_t r;
    int off;
    logic [31:0] b;
    r = v;
    off = int'(v.addr[1:0]);
    r.e_reqcyc = 0; r.e_we = 0; r.e_be = 0; r.e_maddr = 0; r.e_mwdata = 0;
    r.e_wben = 0; r.e_wbdata = 0; r.e_err = 0; r.e_lat = 1;
    if ((v.mr && v.mw) || (((v.mr && !v.lb) || (v.mw && !v.sb)) && off != 0)) begin
      r.e_err = 1;
    end else if (!v.mr && !v.mw) begin
      r.e_wben = v.rw; r.e_wbdata = v.addr;
    end else begin
      r.e_maddr = v.addr & ~32'h3;
      r.e_we = v.mw;
      r.e_be = (v.mw && v.sb) ? 4'(1 << off) : 4'hF;
      r.e_mwdata = (v.mw && v.sb) ? v.wdata[7:0] * 32'h0101_0101 : v.wdata;
      if (v.ack_dly >= ACK_TO) begin
        r.e_reqcyc = ACK_TO; r.e_lat = ACK_TO + 1; r.e_err = 1;
      end else begin
        r.e_reqcyc = v.ack_dly + 1; r.e_lat = v.ack_dly + 2;
        if (v.mr) begin
          r.e_wben = v.rw;
          if (v.lb) begin
            b = (v.rdata >> (8 * off)) & 32'hFF;
            r.e_wbdata = (b >= 128) ? (b | 32'hFFFF_FF00) : b;
          end else begin
            r.e_wbdata = v.rdata;
          end
        end
      end
    end
    return r;
  endfunction

  task automatic do_txn(input vec_t v, output obs_t o);
    o = '{default: 0};
    o.lat = -1; o.stable = 1; o.hold_stable = 1;
    for (int i = 0; i < 20 && !in_ready; i++) step();
    memread = v.mr; memwrite = v.mw; regwrite = v.rw; is_lb = v.lb; is_sb = v.sb;
    addr = v.addr; wdata = v.wdata; rd_in = v.rd; in_valid = 1'b1;
    step();
    in_valid = 1'b0; memread = 1'b0; memwrite = 1'b0; addr = $urandom; wdata = $urandom;
    for (int k = 1; k <= 40; k++) begin
      if (out_valid) begin
        o.lat = k; o.wben = wb_en; o.wbdata = wb_data; o.wbrd = wb_rd; o.errv = err;
        o.req_at_done = mem_req; o.rdy_at_done = in_ready;
        break;
      end
      if (mem_req) begin
        if (o.reqcyc == 0) begin
          o.we = mem_we; o.be = mem_be; o.maddr = mem_addr; o.mwdata = mem_wdata;
        end else if (mem_we !== o.we || mem_be !== o.be || mem_addr !== o.maddr ||
                     mem_wdata !== o.mwdata) begin
          o.stable = 0;
        end
        if (o.reqcyc == v.ack_dly) begin
          mem_ack = 1'b1; mem_rdata = v.rdata;
        end
        o.reqcyc++;
      end
      step();
      mem_ack = 1'b0; mem_rdata = $urandom;
    end
    out_ready = 1'b0;
    for (int h = 0; h < v.hold; h++) begin
      mem_ack = 1'b1;                  // stray ack while holding must be ignored
      step();
      mem_ack = 1'b0;
      if (!out_valid || wb_en !== o.wben || wb_data !== o.wbdata || err !== o.errv ||
          wb_rd !== o.wbrd || in_ready || mem_req) o.hold_stable = 0;
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    o.rel_ok = !out_valid && in_ready;
  endtask

  task automatic check_vec(input string t, input vec_t v, input obs_t o);
    chk({t, " req_cycles"}, o.reqcyc, v.e_reqcyc);
    if (v.e_reqcyc > 0) begin
      chk({t, " mem_we"}, o.we, v.e_we);
      chk({t, " mem_be"}, o.be, v.e_be);
      chk({t, " mem_addr"}, o.maddr, v.e_maddr);
      if (v.e_we) chk({t, " mem_wdata"}, o.mwdata, v.e_mwdata);
      chk({t, " req_stable"}, o.stable, 1);
    end
    chk({t, " latency"}, o.lat, v.e_lat);
    chk({t, " err"}, o.errv, v.e_err);
    chk({t, " wb_en"}, o.wben, v.e_wben);
    if (!v.e_err) chk({t, " wb_data"}, o.wbdata, v.e_wbdata);
    chk({t, " wb_rd"}, o.wbrd, v.rd);
    chk({t, " req_low_in_done"}, o.req_at_done, 0);
    chk({t, " in_ready_low_in_done"}, o.rdy_at_done, 0);
    chk({t, " hold_stable"}, o.hold_stable, 1);
    chk({t, " release"}, o.rel_ok, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    obs_t o;
    vec_t v;
    //            mr mw rw lb sb addr          wdata         rd  ack rdata         hold
    vecs[0] = vexp(vin(1,0,1,1,0, 32'h0000_1003, 32'h0,        5,  0, 32'h80FF_1234, 0),
                   1, 0, 4'hF, 32'h0000_1000, 32'h0, 2, 1, 32'hFFFF_FF80, 0);
    vecs[1] = vexp(vin(0,1,0,0,1, 32'h0000_2002, 32'h0000_00AB, 0,  2, 32'h0,        0),
                   3, 1, 4'b0100, 32'h0000_2000, 32'hABAB_ABAB, 4, 0, 32'h0, 0);
    vecs[2] = vexp(vin(1,0,1,0,0, 32'h0000_3001, 32'h0,        7,  0, 32'h0,        0),
                   0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 32'h0, 1);
    vecs[3] = vexp(vin(1,0,1,0,0, 32'h0000_4000, 32'h0,        3, 99, 32'h5555_5555, 2),
                   4, 0, 4'hF, 32'h0000_4000, 32'h0, 5, 0, 32'h0, 1);
    vecs[4] = vexp(vin(0,0,1,0,0, 32'hDEAD_BEEF, 32'h0,        9,  0, 32'h0,        5),
                   0, 0, 4'h0, 32'h0, 32'h0, 1, 1, 32'hDEAD_BEEF, 0);
    vecs[5] = vexp(vin(0,1,1,0,0, 32'h0000_5004, 32'h1234_5678, 4,  1, 32'h0,        1),
                   2, 1, 4'hF, 32'h0000_5004, 32'h1234_5678, 3, 0, 32'h0, 0);
    vecs[6] = vexp(vin(1,0,1,0,0, 32'h0000_6008, 32'h0,       31,  0, 32'hCAFE_F00D, 0),
                   1, 0, 4'hF, 32'h0000_6008, 32'h0, 2, 1, 32'hCAFE_F00D, 0);
    vecs[7] = vexp(vin(1,1,1,0,0, 32'h0000_7000, 32'h0,        2,  0, 32'h0,        0),
                   0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 32'h0, 1);
    vecs[8] = vexp(vin(1,0,1,1,0, 32'h0000_8001, 32'h0,       12,  1, 32'h1122_5344, 0),
                   2, 0, 4'hF, 32'h0000_8000, 32'h0, 3, 1, 32'h0000_0053, 0);
    vecs[9] = vexp(vin(0,1,0,0,0, 32'h0000_9002, 32'hFFFF_FFFF, 1,  0, 32'h0,        0),
                   0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 32'h0, 1);

    rst = 1'b1; in_valid = 0; memread = 0; memwrite = 0; regwrite = 0; is_lb = 0; is_sb = 0;
    addr = 0; wdata = 0; rd_in = 0; mem_ack = 0; mem_rdata = 0; out_ready = 0;
    step(); step();
    chk("rst mem_req", mem_req, 0);
    chk("rst mem_we", mem_we, 0);
    chk("rst mem_be", mem_be, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst mem_wdata", mem_wdata, 0);
    chk("rst out_valid", out_valid, 0);
    chk("rst wb_en", wb_en, 0);
    chk("rst wb_rd", wb_rd, 0);
    chk("rst wb_data", wb_data, 0);
    chk("rst err", err, 0);
    chk("rst in_ready", in_ready, 1);
    @(negedge clk); rst = 1'b0;
    step();

    for (int i = 0; i < 10; i++) begin
      do_txn(vecs[i], o);
      check_vec($sformatf("vec%0d", i), vecs[i], o);
    end

    // Reset in the middle of an outstanding access abandons it.
    memread = 1; is_lb = 0; regwrite = 1; addr = 32'h0000_0100; rd_in = 3; in_valid = 1;
    step();
    in_valid = 0; memread = 0;
    step();
    chk("midrst req_before", mem_req, 1);
    @(negedge clk); rst = 1'b1; #1;
    chk("midrst mem_req", mem_req, 0);
    chk("midrst out_valid", out_valid, 0);
    @(negedge clk); rst = 1'b0;
    step();
    chk("midrst in_ready", in_ready, 1);
    step(); step();
    chk("midrst no_output", out_valid, 0);
    chk("midrst no_req", mem_req, 0);

    for (int i = 0; i < 150; i++) begin
      v = vin(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              $urandom, $urandom, 5'($urandom), $urandom_range(0, ACK_TO + 1), $urandom,
              $urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) v.addr[1:0] = 2'b00;
      if ($urandom_range(0, 3) == 0) begin v.mr = 0; v.mw = 0; end
      v = model(v);
      do_txn(v, o);
      check_vec($sformatf("rnd%0d", i), v, o);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
